// File: rtl/traffic_intersection_ctrl_pkg.sv
// Shared definitions for the two-road intersection controller: FSM state
// encodings, lamp codes and the packed lamp bundle.
package traffic_intersection_ctrl_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_MAIN_G    = 4'd0,
    S_MAIN_Y    = 4'd1,
    S_ALLRED_A  = 4'd2,
    S_SIDE_G    = 4'd3,
    S_SIDE_Y    = 4'd4,
    S_ALLRED_B  = 4'd5,
    S_PED_WALK  = 4'd6,
    S_PED_FLASH = 4'd7,
    S_NIGHT     = 4'd8
  } state_e;

  // Vehicle lamps are {R,Y,G}, pedestrian lamp is {WALK,DONT}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam logic [1:0] PED_WALK = 2'b10;
  localparam logic [1:0] PED_DONT = 2'b01;
  localparam logic [1:0] PED_OFF  = 2'b00;

  typedef struct packed {
    logic [2:0] main;
    logic [2:0] side;
    logic [1:0] ped;
  } lamps_t;

  localparam lamps_t LAMPS_ALL_RED = '{main: LAMP_RED, side: LAMP_RED, ped: PED_DONT};

endpackage

// File: rtl/traffic_intersection_ctrl_phase_timer.sv
// Phase duration down-counter: loaded with (duration-1) on state entry,
// done while the count reads zero.
module traffic_intersection_ctrl_phase_timer #(
  parameter int unsigned       CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins; otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller with latched pedestrian request, all-red
// clearance and flashing night mode; Moore outputs decoded from registers.
module traffic_intersection_ctrl
  import traffic_intersection_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned T_GREEN     = 20,
  parameter int unsigned T_YELLOW    = 4,
  parameter int unsigned T_ALLRED    = 2,
  parameter int unsigned T_PED_WALK  = 10,
  parameter int unsigned T_PED_FLASH = 6,
  parameter int unsigned FLASH_HALF  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic [1:0] ped_light,
  output logic       ped_wait
);

  localparam int unsigned FLASH_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  state_e             state_q;
  state_e             state_d;
  logic               state_chg;
  logic               timer_done;
  logic [CNT_W-1:0]   timer_load_val;
  logic               ped_q;
  logic               ped_d;
  logic               flash_q;
  logic               flash_d;
  logic [FLASH_W-1:0] fcnt_q;
  logic [FLASH_W-1:0] fcnt_d;
  lamps_t             lamps;

  // Cycles-minus-one spent in each state
  function automatic logic [CNT_W-1:0] dur_m1(input state_e s);
    case (s)
      S_MAIN_G, S_SIDE_G: dur_m1 = CNT_W'(T_GREEN - 1);
      S_MAIN_Y, S_SIDE_Y: dur_m1 = CNT_W'(T_YELLOW - 1);
      S_PED_WALK:         dur_m1 = CNT_W'(T_PED_WALK - 1);
      S_PED_FLASH:        dur_m1 = CNT_W'(T_PED_FLASH - 1);
      default:            dur_m1 = CNT_W'(T_ALLRED - 1);
    endcase
  endfunction

  assign state_chg      = (state_d != state_q);
  assign timer_load_val = dur_m1(state_d);

  traffic_intersection_ctrl_phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(T_ALLRED - 1))
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_chg),
    .load_val (timer_load_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_ALLRED_B;
    end else begin
      state_q <= state_d;
    end
  end

  // Night request is honoured only when leaving a clearance state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_MAIN_G:    if (timer_done) state_d = S_MAIN_Y;
      S_MAIN_Y:    if (timer_done) state_d = S_ALLRED_A;
      S_ALLRED_A:  if (timer_done) state_d = night_mode ? S_NIGHT : S_SIDE_G;
      S_SIDE_G:    if (timer_done) state_d = S_SIDE_Y;
      S_SIDE_Y:    if (timer_done) state_d = S_ALLRED_B;
      S_ALLRED_B: begin
        if (timer_done) begin
          if (night_mode) begin
            state_d = S_NIGHT;
          end else if (ped_q) begin
            state_d = S_PED_WALK;
          end else begin
            state_d = S_MAIN_G;
          end
        end
      end
      S_PED_WALK:  if (timer_done) state_d = S_PED_FLASH;
      S_PED_FLASH: if (timer_done) state_d = S_MAIN_G;
      S_NIGHT:     if (!night_mode) state_d = S_ALLRED_B;
      default:     state_d = S_ALLRED_B;
    endcase
  end

  // Pending request: clear on entry to PED_WALK beats a coincident press
  always_comb begin
    ped_d = ped_q | ped_req;
    if (state_chg && (state_d == S_PED_WALK)) begin
      ped_d = 1'b0;
    end
  end

  // Flash phase free-runs, restarting "on" when a flashing state is entered
  always_comb begin
    flash_d = flash_q;
    fcnt_d  = fcnt_q;
    if (state_chg && ((state_d == S_PED_FLASH) || (state_d == S_NIGHT))) begin
      flash_d = 1'b1;
      fcnt_d  = FLASH_W'(FLASH_HALF - 1);
    end else if (fcnt_q == '0) begin
      flash_d = ~flash_q;
      fcnt_d  = FLASH_W'(FLASH_HALF - 1);
    end else begin
      fcnt_d = fcnt_q - FLASH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ped_q   <= 1'b0;
      flash_q <= 1'b1;
      fcnt_q  <= FLASH_W'(FLASH_HALF - 1);
    end else begin
      ped_q   <= ped_d;
      flash_q <= flash_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Lamp decode; every state not listed shows all-red with don't-walk
  always_comb begin
    lamps = LAMPS_ALL_RED;
    case (state_q)
      S_MAIN_G:    lamps.main = LAMP_GRN;
      S_MAIN_Y:    lamps.main = LAMP_YEL;
      S_SIDE_G:    lamps.side = LAMP_GRN;
      S_SIDE_Y:    lamps.side = LAMP_YEL;
      S_PED_WALK:  lamps.ped  = PED_WALK;
      S_PED_FLASH: lamps.ped  = flash_q ? PED_WALK : PED_OFF;
      S_NIGHT: begin
        lamps.main = flash_q ? LAMP_YEL : LAMP_OFF;
        lamps.side = flash_q ? LAMP_RED : LAMP_OFF;
        lamps.ped  = PED_OFF;
      end
      default: ;
    endcase
  end

  assign main_light = lamps.main;
  assign side_light = lamps.side;
  assign ped_light  = lamps.ped;
  assign ped_wait   = ped_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Scoreboard bench for traffic_intersection_ctrl: directed phases push expected
// lamps per cycle, a negedge monitor pops and compares, plus a safety check.
module tb_traffic_intersection_ctrl;
  import traffic_intersection_ctrl_pkg::*;

  typedef struct packed {
    logic [2:0] m;
    logic [2:0] s;
    logic [1:0] p;
    logic       w;
    logic [7:0] tid;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       ped_req;
  logic       night_mode;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic [1:0] ped_light;
  logic       ped_wait;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass;
  int   n_total;
  logic inv_en;

  traffic_intersection_ctrl #(
    .CNT_W       (8),
    .T_GREEN     (4),
    .T_YELLOW    (2),
    .T_ALLRED    (1),
    .T_PED_WALK  (3),
    .T_PED_FLASH (2),
    .FLASH_HALF  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ped_req    (ped_req),
    .night_mode (night_mode),
    .main_light (main_light),
    .side_light (side_light),
    .ped_light  (ped_light),
    .ped_wait   (ped_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: sequence check against the scoreboard plus the safety invariant
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_total++;
      if ({main_light, side_light, ped_light, ped_wait} === {mon_e.m, mon_e.s, mon_e.p, mon_e.w}) begin
        n_pass++;
      end else begin
        $display("FAIL t%0d seq @%0t: got main=%b side=%b ped=%b wait=%b, want main=%b side=%b ped=%b wait=%b",
                 mon_e.tid, $time, main_light, side_light, ped_light, ped_wait,
                 mon_e.m, mon_e.s, mon_e.p, mon_e.w);
      end
    end
    if (inv_en) begin
      n_total++;
      if (((main_light == LAMP_RED) || (side_light == LAMP_RED) || (main_light == LAMP_OFF && side_light == LAMP_OFF))
          && ((ped_light != PED_WALK) || (main_light == LAMP_RED && side_light == LAMP_RED))) begin
        n_pass++;
      end else begin
        $display("FAIL safety @%0t: got main=%b side=%b ped=%b, want at most one road non-red and walk only with all-red",
                 $time, main_light, side_light, ped_light);
      end
    end
  end

  // Drive inputs for the next edge and record the lamps expected after it
  task automatic step(input logic pr, input logic nm, input logic rn,
                      input logic [2:0] em, input logic [2:0] es, input logic [1:0] ep,
                      input logic ew, input int tid);
    exp_t e;
    @(negedge clk);
    #1;
    ped_req    = pr;
    night_mode = nm;
    rst_n      = rn;
    e.m = em; e.s = es; e.p = ep; e.w = ew; e.tid = 8'(tid);
    exp_q.push_back(e);
  endtask

  task automatic phase(input logic pr, input logic nm,
                       input logic [2:0] em, input logic [2:0] es, input logic [1:0] ep,
                       input int n, input logic ew, input int tid);
    for (int i = 0; i < n; i++) step(pr, nm, 1'b1, em, es, ep, ew, tid);
  endtask

  // Remainder of a cycle after MAIN_G: MAIN_Y, ALLRED_A, SIDE_G, SIDE_Y, ALLRED_B
  task automatic rest_after_main(input logic ew, input int tid);
    phase(1'b0, 1'b0, LAMP_YEL, LAMP_RED, PED_DONT, 2, ew, tid);
    phase(1'b0, 1'b0, LAMP_RED, LAMP_RED, PED_DONT, 1, ew, tid);
    phase(1'b0, 1'b0, LAMP_RED, LAMP_GRN, PED_DONT, 4, ew, tid);
    phase(1'b0, 1'b0, LAMP_RED, LAMP_YEL, PED_DONT, 2, ew, tid);
    phase(1'b0, 1'b0, LAMP_RED, LAMP_RED, PED_DONT, 1, ew, tid);
  endtask

  task automatic normal_period(input int tid);
    phase(1'b0, 1'b0, LAMP_GRN, LAMP_RED, PED_DONT, 4, 1'b0, tid);
    rest_after_main(1'b0, tid);
  endtask

  task automatic ped_phase(input int tid);
    phase(1'b0, 1'b0, LAMP_RED, LAMP_RED, PED_WALK, 3, 1'b0, tid);
    step(1'b0, 1'b0, 1'b1, LAMP_RED, LAMP_RED, PED_WALK, 1'b0, tid);
    step(1'b0, 1'b0, 1'b1, LAMP_RED, LAMP_RED, PED_OFF,  1'b0, tid);
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    inv_en     = 1'b0;
    rst_n      = 1'b0;
    ped_req    = 1'b0;
    night_mode = 1'b0;

    // 1: reset state, then two idle 14-cycle periods
    step(1'b0, 1'b0, 1'b0, LAMP_RED, LAMP_RED, PED_DONT, 1'b0, 1);
    inv_en = 1'b1;
    normal_period(1);
    normal_period(1);

    // 2: one-cycle press in MAIN_G, served after ALLRED_B
    step(1'b0, 1'b0, 1'b1, LAMP_GRN, LAMP_RED, PED_DONT, 1'b0, 2);
    step(1'b1, 1'b0, 1'b1, LAMP_GRN, LAMP_RED, PED_DONT, 1'b1, 2);
    phase(1'b0, 1'b0, LAMP_GRN, LAMP_RED, PED_DONT, 2, 1'b1, 2);
    rest_after_main(1'b1, 2);
    ped_phase(2);

    // 3: press coincident with PED_WALK entry is absorbed by the clear
    step(1'b1, 1'b0, 1'b1, LAMP_GRN, LAMP_RED, PED_DONT, 1'b1, 3);
    phase(1'b0, 1'b0, LAMP_GRN, LAMP_RED, PED_DONT, 3, 1'b1, 3);
    rest_after_main(1'b1, 3);
    step(1'b1, 1'b0, 1'b1, LAMP_RED, LAMP_RED, PED_WALK, 1'b0, 3);
    phase(1'b0, 1'b0, LAMP_RED, LAMP_RED, PED_WALK, 2, 1'b0, 3);
    step(1'b0, 1'b0, 1'b1, LAMP_RED, LAMP_RED, PED_WALK, 1'b0, 3);
    step(1'b0, 1'b0, 1'b1, LAMP_RED, LAMP_RED, PED_OFF,  1'b0, 3);
    normal_period(3);

    // 4: night requested during SIDE_G, taken at ALLRED_B exit
    phase(1'b0, 1'b0, LAMP_GRN, LAMP_RED, PED_DONT, 4, 1'b0, 4);
    phase(1'b0, 1'b0, LAMP_YEL, LAMP_RED, PED_DONT, 2, 1'b0, 4);
    phase(1'b0, 1'b0, LAMP_RED, LAMP_RED, PED_DONT, 1, 1'b0, 4);
    phase(1'b0, 1'b0, LAMP_RED, LAMP_GRN, PED_DONT, 1, 1'b0, 4);
    phase(1'b0, 1'b1, LAMP_RED, LAMP_GRN, PED_DONT, 3, 1'b0, 4);
    phase(1'b0, 1'b1, LAMP_RED, LAMP_YEL, PED_DONT, 2, 1'b0, 4);
    phase(1'b0, 1'b1, LAMP_RED, LAMP_RED, PED_DONT, 1, 1'b0, 4);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b1, 1'b1, LAMP_YEL, LAMP_RED, PED_OFF, 1'b0, 4);
      else            step(1'b0, 1'b1, 1'b1, LAMP_OFF, LAMP_OFF, PED_OFF, 1'b0, 4);
    end
    step(1'b0, 1'b0, 1'b1, LAMP_RED, LAMP_RED, PED_DONT, 1'b0, 4);
    step(1'b0, 1'b0, 1'b1, LAMP_GRN, LAMP_RED, PED_DONT, 1'b0, 4);

    // 4b: night at ALLRED_A exit overrides nothing pending is lost
    step(1'b1, 1'b0, 1'b1, LAMP_GRN, LAMP_RED, PED_DONT, 1'b1, 14);
    phase(1'b0, 1'b0, LAMP_GRN, LAMP_RED, PED_DONT, 2, 1'b1, 14);
    phase(1'b0, 1'b0, LAMP_YEL, LAMP_RED, PED_DONT, 2, 1'b1, 14);
    phase(1'b0, 1'b1, LAMP_RED, LAMP_RED, PED_DONT, 1, 1'b1, 14);
    step(1'b0, 1'b1, 1'b1, LAMP_YEL, LAMP_RED, PED_OFF, 1'b1, 14);
    step(1'b0, 1'b1, 1'b1, LAMP_OFF, LAMP_OFF, PED_OFF, 1'b1, 14);
    step(1'b0, 1'b1, 1'b1, LAMP_YEL, LAMP_RED, PED_OFF, 1'b1, 14);
    step(1'b0, 1'b0, 1'b1, LAMP_RED, LAMP_RED, PED_DONT, 1'b1, 14);
    ped_phase(14);

    // 5: reset mid SIDE_G with a pending request
    step(1'b1, 1'b0, 1'b1, LAMP_GRN, LAMP_RED, PED_DONT, 1'b1, 5);
    phase(1'b0, 1'b0, LAMP_GRN, LAMP_RED, PED_DONT, 3, 1'b1, 5);
    phase(1'b0, 1'b0, LAMP_YEL, LAMP_RED, PED_DONT, 2, 1'b1, 5);
    phase(1'b0, 1'b0, LAMP_RED, LAMP_RED, PED_DONT, 1, 1'b1, 5);
    phase(1'b0, 1'b0, LAMP_RED, LAMP_GRN, PED_DONT, 2, 1'b1, 5);
    step(1'b0, 1'b0, 1'b0, LAMP_RED, LAMP_RED, PED_DONT, 1'b0, 5);
    normal_period(5);
    normal_period(5);

    // 6: random buttons and night toggling, safety invariant only
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      #1;
      rst_n   = 1'b1;
      ped_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 149) == 0) night_mode = ~night_mode;
    end

    @(negedge clk);
    #1;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d expected entries left, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
